// File: rtl/sample_readout.sv
// Streams the circular sample buffer over the UART TX core as
// header, samples oldest-first, then an 8-bit checksum of the samples.
module sample_readout #(
    parameter int         SAMPLE_DEPTH = 8,
    parameter logic [7:0] HEADER_BYTE  = 8'hAA
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [SAMPLE_DEPTH-1:0] offset,
    output logic [SAMPLE_DEPTH-1:0] mem_addr,
    output logic                    mem_re,
    input  logic [7:0]              mem_data,
    input  logic                    tx_active,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    output logic                    busy,
    output logic                    done
);

    // state     | meaning
    // IDLE      | waiting for start
    // HDR       | load header byte
    // FETCH     | RAM read at current address
    // LATCH     | capture sample, accumulate checksum, advance address
    // SEND      | wait for UART idle, pulse tx_start
    // WAIT_ACK  | wait for UART to report busy
    // WAIT_DONE | wait for UART idle, pick next byte
    // SUM       | load checksum byte
    // FIN       | done pulse
    typedef enum logic [3:0] {
        IDLE, HDR, FETCH, LATCH, SEND, WAIT_ACK, WAIT_DONE, SUM, FIN
    } state_t;

    typedef enum logic [1:0] {K_HDR, K_SAMPLE, K_SUM} kind_t;

    localparam logic [SAMPLE_DEPTH-1:0] HALF     = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};
    localparam logic [SAMPLE_DEPTH-1:0] ADDR_ONE = {{(SAMPLE_DEPTH-1){1'b0}}, 1'b1};
    localparam logic [SAMPLE_DEPTH:0]   CNT_ONE  = {{SAMPLE_DEPTH{1'b0}}, 1'b1};

    state_t                  state, state_nxt;
    kind_t                   kind;
    logic [SAMPLE_DEPTH-1:0] addr;
    logic [SAMPLE_DEPTH:0]   cnt;
    logic [7:0]              csum;
    logic                    abort_flag;

    always_ff @(posedge clk_50mhz) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_re    = 1'b0;
        tx_start  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = HDR;
            end
            HDR:   state_nxt = SEND;
            FETCH: begin
                mem_re    = 1'b1;
                state_nxt = LATCH;
            end
            LATCH: state_nxt = SEND;
            SEND: begin
                if (!tx_active) begin
                    tx_start  = 1'b1;
                    state_nxt = WAIT_ACK;
                end
            end
            WAIT_ACK: if (tx_active) state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (!tx_active) begin
                    if (abort_flag) state_nxt = FIN;
                    else begin
                        case (kind)
                            K_HDR:    state_nxt = FETCH;
                            K_SAMPLE: state_nxt = cnt[SAMPLE_DEPTH] ? SUM : FETCH;
                            default:  state_nxt = FIN;
                        endcase
                    end
                end
            end
            SUM: state_nxt = SEND;
            FIN: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            addr       <= '0;
            cnt        <= '0;
            csum       <= '0;
            tx_data    <= HEADER_BYTE;
            kind       <= K_HDR;
            abort_flag <= 1'b0;
        end else begin
            // abort during IDLE (even alongside start) never reaches the flag
            if (state == IDLE) abort_flag <= 1'b0;
            else               abort_flag <= abort_flag | abort;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr <= offset + HALF;
                        cnt  <= '0;
                        csum <= '0;
                    end
                end
                HDR: begin
                    tx_data <= HEADER_BYTE;
                    kind    <= K_HDR;
                end
                LATCH: begin
                    tx_data <= mem_data;
                    csum    <= csum + mem_data;
                    addr    <= addr + ADDR_ONE;
                    cnt     <= cnt + CNT_ONE;
                    kind    <= K_SAMPLE;
                end
                SUM: begin
                    tx_data <= csum;
                    kind    <= K_SUM;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr = addr;

endmodule
